mips_multicycle_core: RTL

MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

---
 rtl/mips_pkg.sv | 68 ++++++
 rtl/mips_regfile.sv | 43 ++++
 rtl/mips_multicycle_core.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: FSM states, opcode/funct
// constants, ALU operation encoding and the ALU evaluation helper.
package mips_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    // Everything that is not an R-type ALU op uses the adder (addi, address calc).
    function automatic alu_op_e alu_op_for(input logic [5:0] op, input logic [5:0] funct);
        alu_op_e sel;
        sel = ALU_ADD;
        if (op == OP_RTYPE) begin
            case (funct)
                F_SUB:   sel = ALU_SUB;
                F_AND:   sel = ALU_AND;
                F_OR:    sel = ALU_OR;
                F_SLT:   sel = ALU_SLT;
                default: sel = ALU_ADD;
            endcase
        end
        return sel;
    endfunction

    function automatic logic [XLEN-1:0] alu_eval(input alu_op_e op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [XLEN-1:0] res;
        case (op)
            ALU_SUB: res = a - b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_SLT: res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: res = a + b;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// Register file for the multicycle MIPS core: two asynchronous read ports,
// one synchronous write port, R0 hard-wired to zero, asynchronous active-low reset.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int NUM_REGS = 32,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_b,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core with one unified, registered memory port.
// Optional feature macro: MIPS_BNE_EN enables bne (op 05); otherwise op 05 halts.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        halted,
    output logic [31:0] retired
);

    localparam int RAW = $clog2(NUM_REGS);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] retired_q, retired_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd, wsel;
    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign funct = ir_q[5:0];

    logic [31:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic        rf_we;

    assign wsel     = (op == OP_RTYPE) ? rd : rt;
    assign rf_we    = (state_q == WB);
    assign rf_wdata = (op == OP_LW) ? mdr_q : alu_q;

    mips_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .raddr_a (rs[RAW-1:0]),
        .rdata_a (rf_rdata_a),
        .raddr_b (rt[RAW-1:0]),
        .rdata_b (rf_rdata_b),
        .we      (rf_we),
        .waddr   (wsel[RAW-1:0]),
        .wdata   (rf_wdata)
    );

    function automatic logic is_legal(input logic [5:0] o, input logic [5:0] f);
        logic ok;
        case (o)
            OP_RTYPE: ok = f inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MIPS_BNE_EN
            OP_BNE:   ok = 1'b1;
`endif
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic br_taken;
    always_comb begin
        br_taken = (op == OP_BEQ) && (a_q == b_q);
`ifdef MIPS_BNE_EN
        if ((op == OP_BNE) && (a_q != b_q)) begin
            br_taken = 1'b1;
        end
`endif
    end

    // FETCH and MEM issue the request on entry and complete on mem_ready,
    // so mem_ready is only looked at while a request is actually outstanding.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        imm_d       = imm_q;
        alu_d       = alu_q;
        mdr_d       = mdr_q;
        retired_d   = retired_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            FETCH: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc_q;
                end else if (mem_ready) begin
                    mem_req_d = 1'b0;
                    ir_d      = mem_rdata;
                    pc_d      = pc_q + 32'd4;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                a_d     = rf_rdata_a;
                b_d     = rf_rdata_b;
                imm_d   = {{16{ir_q[15]}}, ir_q[15:0]};
                state_d = is_legal(op, funct) ? EXEC : HALT;
            end
            EXEC: begin
                case (op)
                    OP_LW, OP_SW: begin
                        alu_d   = a_q + imm_q;
                        state_d = MEM;
                    end
                    OP_J: begin
                        pc_d      = {pc_q[31:28], ir_q[25:0], 2'b00};
                        retired_d = retired_q + 32'd1;
                        state_d   = FETCH;
                    end
                    OP_BEQ, OP_BNE: begin
                        if (br_taken) begin
                            pc_d = pc_q + {imm_q[29:0], 2'b00};
                        end
                        retired_d = retired_q + 32'd1;
                        state_d   = FETCH;
                    end
                    default: begin
                        alu_d   = alu_eval(alu_op_for(op, funct), a_q,
                                           (op == OP_ADDI) ? imm_q : b_q);
                        state_d = WB;
                    end
                endcase
            end
            MEM: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = (op == OP_SW);
                    mem_addr_d  = {alu_q[31:2], 2'b00};
                    mem_wdata_d = b_q;
                end else if (mem_ready) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mdr_d     = mem_rdata;
                    if (op == OP_SW) begin
                        retired_d = retired_q + 32'd1;
                        state_d   = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                retired_d = retired_q + 32'd1;
                state_d   = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            alu_q       <= '0;
            mdr_q       <= '0;
            retired_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            imm_q       <= imm_d;
            alu_q       <= alu_d;
            mdr_q       <= mdr_d;
            retired_q   <= retired_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc        = pc_q;
    assign halted    = (state_q == HALT);
    assign retired   = retired_q;

endmodule
